// File: rtl/seq_detect_ctrl.sv
// Programmable serial 4-bit pattern detector with an armed, length-bounded
// detection window, match pulse, saturating match counter and done pulse.
module seq_detect_ctrl #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             x,
  input  logic             x_valid,
  output logic             busy,
  output logic             z,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0]       FILL_FULL = 3'd4;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [1:0]       state, state_next;
  logic [3:0]       pat, pat_next;
  logic             ovl, ovl_next;
  logic [LEN_W-1:0] len, len_next;
  logic [3:0]       hist, hist_next;
  logic [2:0]       fill, fill_next;
  logic [LEN_W-1:0] bits_seen, bits_seen_next;
  logic [CNT_W-1:0] count_next;
  logic             z_next;

  logic [3:0]       hist_shift;
  logic [2:0]       fill_inc;
  logic [LEN_W-1:0] seen_inc;
  logic             hit;

  // Next-state, window bookkeeping and match evaluation
  always_comb begin
    state_next     = state;
    pat_next       = pat;
    ovl_next       = ovl;
    len_next       = len;
    hist_next      = hist;
    fill_next      = fill;
    bits_seen_next = bits_seen;
    count_next     = match_count;
    z_next         = 1'b0;
    hit            = 1'b0;

    hist_shift = {hist[2:0], x};
    fill_inc   = (fill == FILL_FULL) ? FILL_FULL : fill + 3'd1;
    seen_inc   = bits_seen + LEN_W'(1);

    case (state)
      IDLE: begin
        if (start) begin
          pat_next       = cfg_pattern;
          ovl_next       = cfg_overlap;
          len_next       = cfg_len;
          hist_next      = 4'd0;
          fill_next      = 3'd0;
          bits_seen_next = '0;
          count_next     = '0;
          state_next     = (cfg_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // Abort takes priority over a bit arriving on the same edge
        if (abort) begin
          state_next = IDLE;
        end else if (x_valid) begin
          hit            = (fill_inc == FILL_FULL) && (hist_shift == pat);
          hist_next      = hist_shift;
          fill_next      = (hit && !ovl) ? 3'd0 : fill_inc;
          bits_seen_next = seen_inc;
          if (hit) begin
            z_next = 1'b1;
            if (match_count != CNT_MAX) begin
              count_next = match_count + CNT_W'(1);
            end
          end
          if (seen_inc == len) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; busy/done decode the next state so they track it exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pat         <= 4'd0;
      ovl         <= 1'b0;
      len         <= '0;
      hist        <= 4'd0;
      fill        <= 3'd0;
      bits_seen   <= '0;
      match_count <= '0;
      z           <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      pat         <= pat_next;
      ovl         <= ovl_next;
      len         <= len_next;
      hist        <= hist_next;
      fill        <= fill_next;
      bits_seen   <= bits_seen_next;
      match_count <= count_next;
      z           <= z_next;
      busy        <= (state_next == RUN);
      done        <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Randomised scoreboard bench for seq_detect_ctrl; expected pulses come from a
// window-level model that scans the accepted bit list directly.
`timescale 1ns/1ps
module tb_seq_detect_ctrl;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    int cyc;
    bit z;
    bit done;
    int cnt;
  } ev_t;

  logic             clk = 1'b0;
  logic             reset, start, abort, cfg_overlap, x, x_valid;
  logic [3:0]       cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             busy, z, done;
  logic [CNT_W-1:0] match_count;

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  ev_t evq[$];
  bit  bitq[$];
  ev_t e;

  seq_detect_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cfg_len(cfg_len),
    .x(x), .x_valid(x_valid), .busy(busy), .z(z), .done(done),
    .match_count(match_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    cfg_pattern = 4'($urandom);
    cfg_overlap = 1'($urandom);
    cfg_len     = LEN_W'($urandom);
  endtask

  // One window: model computes matches from the list of accepted bits.
  // kill_at >= 0 aborts (or resets, if kill_rst) once kill_at bits are accepted.
  task automatic run_window(input logic [3:0] pat, input bit ovl, input int len,
                            input int kill_at, input bit kill_rst,
                            input int gap_lo, input int gap_hi);
    bit         h[$];
    int         acc = 0;
    int         cnt = 0;
    int         last_end = -1;
    bit         b, hit, fin;
    logic [3:0] w;
    start = 1'b1; abort = 1'b0;
    cfg_pattern = pat; cfg_overlap = ovl; cfg_len = LEN_W'(len);
    x_valid = 1'($urandom); x = 1'($urandom);
    if (len == 0) evq.push_back('{cyc + 1, 1'b0, 1'b1, 0});
    step();
    start = 1'b0;
    scramble();
    while (acc < len) begin
      repeat ($urandom_range(gap_hi, gap_lo)) begin
        x_valid = 1'b0; x = 1'($urandom); start = 1'($urandom); scramble();
        step();
        check("busy_in_gap", int'(busy), 1);
      end
      if (acc == kill_at) begin
        x_valid = 1'($urandom); x = 1'($urandom); start = 1'b0;
        if (kill_rst) begin
          reset = 1'b1; x_valid = 1'b1;
          step();
          reset = 1'b0; x_valid = 1'b0;
          check("rst_busy", int'(busy), 0);
          check("rst_z", int'(z), 0);
          check("rst_done", int'(done), 0);
          check("rst_count", int'(match_count), 0);
        end else begin
          abort = 1'b1;
          step();
          abort = 1'b0; x_valid = 1'b0;
          check("abort_busy", int'(busy), 0);
          check("abort_done", int'(done), 0);
          check("abort_count", int'(match_count), cnt);
        end
        return;
      end
      b = (bitq.size() > 0) ? bitq.pop_front() : 1'($urandom);
      x = b; x_valid = 1'b1; start = 1'($urandom); scramble();
      h.push_back(b);
      acc++;
      hit = 1'b0;
      if (acc >= 4 && (ovl || (acc - 4 > last_end))) begin
        w = {h[acc-4], h[acc-3], h[acc-2], h[acc-1]};
        if (w == pat) begin
          hit = 1'b1;
          last_end = acc - 1;
          if (cnt < CNT_MAX) cnt++;
        end
      end
      fin = (acc == len);
      if (hit || fin) evq.push_back('{cyc + 1, hit, fin, cnt});
      step();
      x_valid = 1'b0;
      if (!fin) check("busy_run", int'(busy), 1);
    end
    // DONE cycle: start here must be ignored
    start = 1'($urandom);
    step();
    start = 1'b0;
    check("idle_after_done", int'(busy), 0);
    check("count_hold", int'(match_count), cnt);
  endtask

  // Monitor: every presented pulse must match the next expected event
  always @(negedge clk) begin
    if (z === 1'b1 || done === 1'b1) begin
      if (evq.size() == 0) begin
        check("unexpected_pulse", int'({z, done}), 0);
      end else begin
        e = evq.pop_front();
        check("ev_cycle", cyc, e.cyc);
        check("ev_z", int'(z), int'(e.z));
        check("ev_done", int'(done), int'(e.done));
        check("ev_count", int'(match_count), e.cnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int len, kill;
    reset = 1'b1; start = 1'b0; abort = 1'b0; x = 1'b0; x_valid = 1'b0;
    cfg_pattern = 4'd0; cfg_overlap = 1'b0; cfg_len = '0;
    repeat (3) step();
    check("reset_busy", int'(busy), 0);
    check("reset_z", int'(z), 0);
    check("reset_done", int'(done), 0);
    check("reset_count", int'(match_count), 0);
    reset = 1'b0;
    step();

    bitq = '{1, 0, 1, 0, 1, 0};
    run_window(4'b1010, 1'b0, 6, -1, 1'b0, 0, 0);
    bitq = '{1, 0, 1, 0, 1, 0};
    run_window(4'b1010, 1'b1, 6, -1, 1'b0, 0, 0);
    repeat (7) bitq.push_back(1'b1);
    run_window(4'b1111, 1'b1, 7, -1, 1'b0, 0, 0);
    repeat (7) bitq.push_back(1'b1);
    run_window(4'b1111, 1'b0, 7, -1, 1'b0, 0, 0);
    bitq = '{1, 0, 1, 0};
    run_window(4'b1010, 1'b1, 4, -1, 1'b0, 3, 3);
    bitq = '{1, 0, 1, 0, 1, 0};
    run_window(4'b1010, 1'b0, 10, 4, 1'b0, 0, 0);
    bitq.delete();
    run_window(4'b0110, 1'b1, 0, -1, 1'b0, 0, 0);
    repeat (20) bitq.push_back(1'b0);
    run_window(4'b0000, 1'b1, 20, -1, 1'b0, 0, 0);
    repeat (10) bitq.push_back(1'b0);
    run_window(4'b0000, 1'b1, 10, 6, 1'b1, 0, 1);
    bitq.delete();

    for (int i = 0; i < 40; i++) begin
      len  = $urandom_range(24, 0);
      kill = ($urandom_range(5, 0) == 0) ? $urandom_range(len, 0) : -1;
      run_window(4'($urandom), 1'($urandom), len, kill, 1'($urandom), 0, 2);
    end

    repeat (3) step();
    check("queue_empty", evq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run controller for serial 4-bit pattern detection. Software arms a detection window with `start`: it chooses the pattern, overlap or non-overlap mode, and window length in valid bits. The block then scans the gated serial stream `x`/`x_valid`, pulses `z` per match, counts matches, and signals `done` at window end. It sits between the config/control logic and the serial input. It generalises the fixed 1010 detectors into one sequenced, programmable engine.

Parameters:
- LEN_W, 8, width of `cfg_len` and of the internal bits-seen counter.
- CNT_W, 8, width of `match_count`. The count saturates at 2^CNT_W-1.

Ports:
- clk, input, 1, system clock. All logic is on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, arm request. Sampled only in IDLE.
- abort, input, 1, terminates an active window. Sampled only in RUN.
- cfg_pattern, input, 4, pattern. Bit 3 is matched first (oldest), bit 0 last (newest).
- cfg_overlap, input, 1, mode: 1 = overlapping, 0 = non-overlapping.
- cfg_len, input, LEN_W, window length in accepted bits.
- x, input, 1, serial data bit.
- x_valid, input, 1, `x` is accepted only when high during RUN.
- busy, output, 1, high while state is RUN.
- z, output, 1, registered one-cycle match pulse.
- done, output, 1, one-cycle window-complete pulse.
- match_count, output, CNT_W, matches in the current or last window.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state=IDLE; busy=0, z=0, done=0, match_count=0.
  - History, fill counter and bits-seen counter cleared.
  - Reset mid-RUN discards the window with no `done` pulse.
- States: IDLE, RUN, DONE. `busy` = (state==RUN); `done` = (state==DONE).
- IDLE:
  - If start=1, latch cfg_pattern, cfg_overlap and cfg_len.
  - On the same edge: clear match_count, history, fill and bits-seen.
  - Next state is RUN if cfg_len≠0, else DONE (zero-length window, count stays 0).
  - Config inputs are ignored outside this latch edge.
- RUN, on each edge with x_valid=1:
  - hist_next = {hist[2:0], x}; fill_next = min(fill+1, 4); bits_seen += 1.
  - Match when fill_next==4 and hist_next==latched pattern.
  - On a match: z<=1 next cycle, match_count += 1, saturating at all-ones.
  - On a match with non-overlap mode, fill is set to 0 instead of fill_next, so the next match needs 4 fresh bits.
  - When the accepted bit is the cfg_len-th (bits_seen_next==len), next state is DONE.
- RUN, on edges with x_valid=0: no change to history, fill, bits_seen or count.
- z is 0 on every cycle that does not follow a matching accepted bit.
- Latency: `z` and `match_count` reflect a bit on the cycle after its acceptance edge. If the last window bit matches, z=1 and done=1 in the same cycle.
- abort=1 in RUN:
  - Next state is IDLE with no `done` pulse. match_count holds its value and busy drops.
  - If abort and a valid bit arrive on the same edge, abort wins and the bit is ignored.
- DONE: stays one cycle, then IDLE unconditionally. `start` in DONE is ignored. match_count holds until the next accepted start.
- `start` during RUN or DONE is ignored, with no queuing.
- Config changes during RUN have no effect.
- No X propagation: all registers are reset, and the case statement has a default of IDLE.

Test Plan:
- Pattern 1010, overlap=0, len=6, stream 1,0,1,0,1,0 (x_valid=1 every cycle) -> z pulses once (after bit 4); done with match_count=1.
- Same stream, overlap=1 -> z after bits 4 and 6; z and done coincide on the last bit; match_count=2.
- Pattern 1111, len=7, seven 1s -> overlap=1: count 4 (bits 4–7); overlap=0: count 1 (bit 4 only).
- Pattern 1010, overlap=1, len=4, bits 1,0,1,0 with x_valid low for 3 cycles between each bit -> count 1; done appears only after the 4th valid bit; busy stays high throughout.
- Abort at bit 5 of a len=10 window with count=1 -> IDLE next cycle, no done, match_count stays 1. A start with len=0 -> done on the next cycle, count 0.
- CNT_W=4, pattern 0000, overlap=1, len=20, all zeros -> 17 raw matches, match_count saturates at 15. Reset asserted mid-run in a second window -> all outputs 0 the next cycle.
